dual_issue_dcache_arbiter: RTL and testbench

Merges the two per-slot data memory requests of the dual-issue pipeline (slot 01 = inst1, slot 02 = inst2) onto the single-port data cache request interface. Sits between the pre-memory stage, which issues requests, and the data cache. Routes in-order cache responses back as data_ok_01/rdata_01 and data_ok_02/rdata_02 to the memory stage. Enforces program order: slot 01 is always issued before slot 02.

---
 rtl/dual_issue_dcache_arbiter_pkg.sv | 26 ++
 rtl/dcache_tag_fifo.sv | 73 +++++++
 rtl/dual_issue_dcache_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dual_issue_dcache_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_dcache_arbiter_pkg.sv
// Shared definitions for the dual-issue data cache arbiter.
// These encodings are also used by the pre-memory stage.
//   grant_state_t : grant FSM state encodings
//   TAG_01/TAG_02 : slot tags stored in the outstanding-request FIFO
//   SIZE_B/H/W    : access size encodings on size_0x / data_cache_size
package dual_issue_dcache_arbiter_pkg;

    typedef enum logic [1:0] {
        G_IDLE   = 2'd0,
        G_LOCK01 = 2'd1,
        G_LOCK02 = 2'd2
    } grant_state_t;

    localparam logic TAG_01 = 1'b0;
    localparam logic TAG_02 = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Route a cache response to one slot: the data is forced to zero when that slot is not selected
    function automatic logic [31:0] route_rdata(input logic sel, input logic [31:0] rdata);
        return sel ? rdata : 32'h0000_0000;
    endfunction

endpackage

// File: rtl/dcache_tag_fifo.sv
// In-order 1-bit tag FIFO that records the slot of each cache request that has been
// accepted but not yet answered.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   i_push, i_push_tag    : enqueue one tag
//   i_pop                 : dequeue the head tag (ignored when empty)
//   o_head_tag            : tag at the FIFO head
//   o_full, o_empty       : occupancy flags
//   o_count               : number of stored tags (0..OUTST_DEPTH)
module dcache_tag_fifo #(
    parameter int OUTST_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_push_tag,
    input  logic             i_pop,
    output logic             o_head_tag,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

    logic [OUTST_DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign o_full     = (r_count == CNT_W'(OUTST_DEPTH));
    assign o_empty    = (r_count == {CNT_W{1'b0}});
    assign o_count    = r_count;
    assign o_head_tag = r_mem[r_rd_ptr];

    // When full, a push is only legal together with a pop that frees the slot
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage and pointers; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem    <= {OUTST_DEPTH{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_tag;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dual_issue_dcache_arbiter.sv
// Merges the two per-slot data memory requests of the dual-issue pipeline onto the
// single-port data cache and routes the in-order responses back to their slots.
// Slot 01 (inst1) is always issued before slot 02 (inst2).
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   req/wr/size/addr/wstrb/wdata_0x    : per-slot request from the pre-memory stage
//   addr_ok_0x                         : slot request accepted by the cache this cycle
//   data_ok_0x, rdata_0x               : per-slot response to the memory stage
//   data_cache_*                       : muxed request / response on the cache port
//   outst_cnt                          : accepted-but-unanswered request count
//   err_unexp                          : sticky, response seen with nothing outstanding
module dual_issue_dcache_arbiter
    import dual_issue_dcache_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_01,
    input  logic             wr_01,
    input  logic [1:0]       size_01,
    input  logic [31:0]      addr_01,
    input  logic [3:0]       wstrb_01,
    input  logic [31:0]      wdata_01,
    input  logic             req_02,
    input  logic             wr_02,
    input  logic [1:0]       size_02,
    input  logic [31:0]      addr_02,
    input  logic [3:0]       wstrb_02,
    input  logic [31:0]      wdata_02,
    output logic             addr_ok_01,
    output logic             addr_ok_02,
    output logic             data_ok_01,
    output logic             data_ok_02,
    output logic [31:0]      rdata_01,
    output logic [31:0]      rdata_02,
    output logic             data_cache_req,
    output logic             data_cache_wr,
    output logic [1:0]       data_cache_size,
    output logic [31:0]      data_cache_addr,
    output logic [3:0]       data_cache_wstrb,
    output logic [31:0]      data_cache_wdata,
    input  logic             data_cache_addr_ok,
    input  logic             data_cache_data_ok,
    input  logic [31:0]      data_cache_rdata,
    output logic [CNT_W-1:0] outst_cnt,
    output logic             err_unexp
);

    grant_state_t r_state;
    grant_state_t w_next_state;
    logic         w_pres_01;
    logic         w_pres_02;
    logic         w_full;
    logic         w_empty;
    logic         w_head_tag;
    logic         w_push;
    logic         w_pop;
    logic         r_err_unexp;

    // Grant state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= G_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a presented but unaccepted slot locks the port to that slot
    always_comb begin
        w_next_state = G_IDLE;
        if (w_pres_01 && !data_cache_addr_ok) begin
            w_next_state = G_LOCK01;
        end else if (w_pres_02 && !data_cache_addr_ok) begin
            w_next_state = G_LOCK02;
        end else begin
            w_next_state = G_IDLE;
        end
    end

    // Slot presentation. Nothing is granted while reset is asserted so the cache port is
    // quiet at once. A lock is only entered when not full, so it stays presented when full.
    always_comb begin
        w_pres_01 = 1'b0;
        w_pres_02 = 1'b0;
        if (reset) begin
            w_pres_01 = 1'b0;
            w_pres_02 = 1'b0;
        end else begin
            case (r_state)
                G_IDLE: begin
                    // req_01 is checked first so slot 02 never overtakes a pending slot 01
                    if (req_01 && !w_full) begin
                        w_pres_01 = 1'b1;
                    end else if (req_02 && !w_full && !req_01) begin
                        w_pres_02 = 1'b1;
                    end else begin
                        w_pres_01 = 1'b0;
                        w_pres_02 = 1'b0;
                    end
                end
                G_LOCK01: w_pres_01 = 1'b1;
                G_LOCK02: w_pres_02 = 1'b1;
                default: begin
                    w_pres_01 = 1'b0;
                    w_pres_02 = 1'b0;
                end
            endcase
        end
    end

    // Request field mux; all fields are zero when nothing is presented
    always_comb begin
        data_cache_req   = w_pres_01 | w_pres_02;
        data_cache_wr    = 1'b0;
        data_cache_size  = 2'd0;
        data_cache_addr  = 32'h0000_0000;
        data_cache_wstrb = 4'h0;
        data_cache_wdata = 32'h0000_0000;
        if (w_pres_01) begin
            data_cache_wr    = wr_01;
            data_cache_size  = size_01;
            data_cache_addr  = addr_01;
            data_cache_wstrb = wstrb_01;
            data_cache_wdata = wdata_01;
        end else if (w_pres_02) begin
            data_cache_wr    = wr_02;
            data_cache_size  = size_02;
            data_cache_addr  = addr_02;
            data_cache_wstrb = wstrb_02;
            data_cache_wdata = wdata_02;
        end else begin
            data_cache_wr    = 1'b0;
            data_cache_size  = 2'd0;
            data_cache_addr  = 32'h0000_0000;
            data_cache_wstrb = 4'h0;
            data_cache_wdata = 32'h0000_0000;
        end
    end

    // Accept handshake and response routing from the FIFO head tag
    always_comb begin
        addr_ok_01 = w_pres_01 & data_cache_addr_ok;
        addr_ok_02 = w_pres_02 & data_cache_addr_ok;
        w_push     = addr_ok_01 | addr_ok_02;
        w_pop      = data_cache_data_ok & ~w_empty;
        data_ok_01 = w_pop & (w_head_tag == TAG_01);
        data_ok_02 = w_pop & (w_head_tag == TAG_02);
        rdata_01   = route_rdata(data_ok_01, data_cache_rdata);
        rdata_02   = route_rdata(data_ok_02, data_cache_rdata);
    end

    // Sticky error: a response arrived with no request outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_unexp <= 1'b0;
        end else if (data_cache_data_ok && w_empty) begin
            r_err_unexp <= 1'b1;
        end else begin
            r_err_unexp <= r_err_unexp;
        end
    end

    assign err_unexp = r_err_unexp;

    dcache_tag_fifo #(
        .OUTST_DEPTH (OUTST_DEPTH),
        .CNT_W       (CNT_W)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_tag (w_pres_02 ? TAG_02 : TAG_01),
        .i_pop      (w_pop),
        .o_head_tag (w_head_tag),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (outst_cnt)
    );

endmodule

// File: tb/tb_dual_issue_dcache_arbiter.sv
// Directed self-checking bench for dual_issue_dcache_arbiter.
module tb_dual_issue_dcache_arbiter;
    import dual_issue_dcache_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_01, wr_01, req_02, wr_02;
    logic [1:0]  size_01, size_02;
    logic [31:0] addr_01, addr_02, wdata_01, wdata_02;
    logic [3:0]  wstrb_01, wstrb_02;
    logic        addr_ok_01, addr_ok_02, data_ok_01, data_ok_02;
    logic [31:0] rdata_01, rdata_02;
    logic        data_cache_req, data_cache_wr;
    logic [1:0]  data_cache_size;
    logic [31:0] data_cache_addr, data_cache_wdata;
    logic [3:0]  data_cache_wstrb;
    logic        data_cache_addr_ok, data_cache_data_ok;
    logic [31:0] data_cache_rdata;
    logic [2:0]  outst_cnt;
    logic        err_unexp;

    int errors = 0;
    int checks = 0;

    dual_issue_dcache_arbiter #(.OUTST_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_01(req_01), .wr_01(wr_01), .size_01(size_01), .addr_01(addr_01),
        .wstrb_01(wstrb_01), .wdata_01(wdata_01),
        .req_02(req_02), .wr_02(wr_02), .size_02(size_02), .addr_02(addr_02),
        .wstrb_02(wstrb_02), .wdata_02(wdata_02),
        .addr_ok_01(addr_ok_01), .addr_ok_02(addr_ok_02),
        .data_ok_01(data_ok_01), .data_ok_02(data_ok_02),
        .rdata_01(rdata_01), .rdata_02(rdata_02),
        .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
        .data_cache_size(data_cache_size), .data_cache_addr(data_cache_addr),
        .data_cache_wstrb(data_cache_wstrb), .data_cache_wdata(data_cache_wdata),
        .data_cache_addr_ok(data_cache_addr_ok), .data_cache_data_ok(data_cache_data_ok),
        .data_cache_rdata(data_cache_rdata),
        .outst_cnt(outst_cnt), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_01 = 1'b0; wr_01 = 1'b0; size_01 = 2'd0; addr_01 = 32'h0; wstrb_01 = 4'h0; wdata_01 = 32'h0;
        req_02 = 1'b0; wr_02 = 1'b0; size_02 = 2'd0; addr_02 = 32'h0; wstrb_02 = 4'h0; wdata_02 = 32'h0;
        data_cache_addr_ok = 1'b0; data_cache_data_ok = 1'b0; data_cache_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step(); step();
        checks++;
        if ({data_cache_req, addr_ok_01, addr_ok_02, data_ok_01, data_ok_02, err_unexp} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 000000",
                     {data_cache_req, addr_ok_01, addr_ok_02, data_ok_01, data_ok_02, err_unexp});
        end
        checks++;
        if (outst_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", outst_cnt); end
        checks++;
        if ({rdata_01, rdata_02, data_cache_addr} !== 96'h0) begin
            errors++; $display("FAIL reset_data: rdata/addr not zero");
        end
        reset = 1'b0;
    endtask

    task automatic test_both_slots();
        step();
        req_01 = 1'b1; wr_01 = 1'b0; size_01 = SIZE_W; addr_01 = 32'h0000_1000;
        req_02 = 1'b1; wr_02 = 1'b1; size_02 = SIZE_H; addr_02 = 32'h0000_2004;
        wstrb_02 = 4'hC; wdata_02 = 32'hDEAD_BEEF; data_cache_addr_ok = 1'b1;
        #1;
        checks++;
        if ({addr_ok_01, addr_ok_02, data_cache_req} !== 3'b101) begin
            errors++; $display("FAIL both_c0_ok: got %b exp 101", {addr_ok_01, addr_ok_02, data_cache_req});
        end
        checks++;
        if ({data_cache_addr, data_cache_wr, data_cache_size} !== {32'h0000_1000, 1'b0, SIZE_W}) begin
            errors++; $display("FAIL both_c0_fields: addr %h wr %b size %0d", data_cache_addr, data_cache_wr, data_cache_size);
        end
        step();
        req_01 = 1'b0;
        #1;
        checks++;
        if ({addr_ok_01, addr_ok_02} !== 2'b01) begin
            errors++; $display("FAIL both_c1_ok: got %b exp 01", {addr_ok_01, addr_ok_02});
        end
        checks++;
        if ({data_cache_addr, data_cache_wr, data_cache_size, data_cache_wstrb, data_cache_wdata} !==
            {32'h0000_2004, 1'b1, SIZE_H, 4'hC, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL both_c1_fields: addr %h wstrb %h wdata %h", data_cache_addr, data_cache_wstrb, data_cache_wdata);
        end
        step();
        req_02 = 1'b0; data_cache_addr_ok = 1'b0;
        data_cache_data_ok = 1'b1; data_cache_rdata = 32'h1111_1111;
        #1;
        checks++;
        if (outst_cnt !== 3'd2) begin errors++; $display("FAIL both_cnt2: got %0d exp 2", outst_cnt); end
        checks++;
        if ({data_ok_01, data_ok_02, rdata_01, rdata_02} !== {2'b10, 32'h1111_1111, 32'h0}) begin
            errors++; $display("FAIL both_resp1: ok %b r1 %h r2 %h", {data_ok_01, data_ok_02}, rdata_01, rdata_02);
        end
        step();
        data_cache_rdata = 32'h2222_2222;
        #1;
        checks++;
        if ({data_ok_01, data_ok_02, rdata_01, rdata_02} !== {2'b01, 32'h0, 32'h2222_2222}) begin
            errors++; $display("FAIL both_resp2: ok %b r1 %h r2 %h", {data_ok_01, data_ok_02}, rdata_01, rdata_02);
        end
        step();
        data_cache_data_ok = 1'b0; data_cache_rdata = 32'h0;
        #1;
        checks++;
        if (outst_cnt !== 3'd0) begin errors++; $display("FAIL both_cnt0: got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_lock02();
        step();
        req_02 = 1'b1; wr_02 = 1'b0; addr_02 = 32'h0000_3000; data_cache_addr_ok = 1'b0;
        #1;
        checks++;
        if ({data_cache_req, addr_ok_02, data_cache_addr} !== {2'b10, 32'h0000_3000}) begin
            errors++; $display("FAIL lock_c0: req %b ok2 %b addr %h", data_cache_req, addr_ok_02, data_cache_addr);
        end
        step();
        req_01 = 1'b1; wr_01 = 1'b0; addr_01 = 32'h0000_4000;
        #1;
        checks++;
        if ({addr_ok_01, addr_ok_02, data_cache_addr} !== {2'b00, 32'h0000_3000}) begin
            errors++; $display("FAIL lock_c1: ok %b addr %h exp addr 00003000", {addr_ok_01, addr_ok_02}, data_cache_addr);
        end
        step();
        #1;
        checks++;
        if (data_cache_addr !== 32'h0000_3000) begin
            errors++; $display("FAIL lock_c2: addr %h exp 00003000", data_cache_addr);
        end
        step();
        data_cache_addr_ok = 1'b1;
        #1;
        checks++;
        if ({addr_ok_01, addr_ok_02, data_cache_addr} !== {2'b01, 32'h0000_3000}) begin
            errors++; $display("FAIL lock_c3: ok %b addr %h", {addr_ok_01, addr_ok_02}, data_cache_addr);
        end
        step();
        req_02 = 1'b0;
        #1;
        checks++;
        if ({addr_ok_01, addr_ok_02, data_cache_addr} !== {2'b10, 32'h0000_4000}) begin
            errors++; $display("FAIL lock_c4: ok %b addr %h", {addr_ok_01, addr_ok_02}, data_cache_addr);
        end
        step();
        req_01 = 1'b0; data_cache_addr_ok = 1'b0;
        data_cache_data_ok = 1'b1; data_cache_rdata = 32'h3333_3333;
        #1;
        checks++;
        if ({outst_cnt, data_ok_01, data_ok_02, rdata_02} !== {3'd2, 2'b01, 32'h3333_3333}) begin
            errors++; $display("FAIL lock_resp1: cnt %0d ok %b r2 %h", outst_cnt, {data_ok_01, data_ok_02}, rdata_02);
        end
        step();
        data_cache_rdata = 32'h4444_4444;
        #1;
        checks++;
        if ({data_ok_01, data_ok_02, rdata_01} !== {2'b10, 32'h4444_4444}) begin
            errors++; $display("FAIL lock_resp2: ok %b r1 %h", {data_ok_01, data_ok_02}, rdata_01);
        end
        step();
        data_cache_data_ok = 1'b0; data_cache_rdata = 32'h0;
        #1;
        checks++;
        if (outst_cnt !== 3'd0) begin errors++; $display("FAIL lock_cnt0: got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_full();
        step();
        req_01 = 1'b1; addr_01 = 32'h0000_E000; data_cache_addr_ok = 1'b1;
        #1;
        checks++;
        if (addr_ok_01 !== 1'b1) begin errors++; $display("FAIL full_first: ok1 %b exp 1", addr_ok_01); end
        for (int i = 1; i < 4; i++) begin
            step();
            addr_01 = 32'h0000_E000 + 32'(i * 4);
        end
        step();
        #1;
        checks++;
        if (outst_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4: got %0d exp 4", outst_cnt); end
        checks++;
        if ({data_cache_req, addr_ok_01, data_cache_addr} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL full_block: req %b ok1 %b addr %h", data_cache_req, addr_ok_01, data_cache_addr);
        end
        step();
        data_cache_data_ok = 1'b1; data_cache_rdata = 32'h5555_5555;
        #1;
        checks++;
        if ({data_cache_req, data_ok_01, rdata_01} !== {2'b01, 32'h5555_5555}) begin
            errors++; $display("FAIL full_pop: req %b ok1 %b r1 %h", data_cache_req, data_ok_01, rdata_01);
        end
        step();
        data_cache_data_ok = 1'b0; addr_01 = 32'h0000_F000;
        #1;
        checks++;
        if ({outst_cnt, data_cache_req, addr_ok_01, data_cache_addr} !== {3'd3, 2'b11, 32'h0000_F000}) begin
            errors++; $display("FAIL full_reissue: cnt %0d req %b ok1 %b addr %h", outst_cnt, data_cache_req, addr_ok_01, data_cache_addr);
        end
        step();
        req_01 = 1'b0; data_cache_addr_ok = 1'b0; data_cache_data_ok = 1'b1;
        #1;
        checks++;
        if (outst_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4b: got %0d exp 4", outst_cnt); end
        repeat (3) step();
        step();
        data_cache_data_ok = 1'b0;
        #1;
        checks++;
        if ({outst_cnt, err_unexp} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL full_drain: cnt %0d err %b exp 0 0", outst_cnt, err_unexp);
        end
    endtask

    task automatic test_push_pop();
        step();
        req_02 = 1'b1; addr_02 = 32'h0000_6000; data_cache_addr_ok = 1'b1;
        #1;
        checks++;
        if (addr_ok_02 !== 1'b1) begin errors++; $display("FAIL pp_first: ok2 %b exp 1", addr_ok_02); end
        step();
        req_02 = 1'b0; req_01 = 1'b1; addr_01 = 32'h0000_7000;
        #1;
        checks++;
        if (addr_ok_01 !== 1'b1) begin errors++; $display("FAIL pp_second: ok1 %b exp 1", addr_ok_01); end
        step();
        req_01 = 1'b0; req_02 = 1'b1; addr_02 = 32'h0000_8000;
        data_cache_data_ok = 1'b1; data_cache_rdata = 32'h6666_6666;
        #1;
        checks++;
        if ({outst_cnt, addr_ok_02, data_ok_01, data_ok_02, rdata_02} !== {3'd2, 3'b101, 32'h6666_6666}) begin
            errors++; $display("FAIL pp_both: cnt %0d ok2 %b dok %b r2 %h", outst_cnt, addr_ok_02, {data_ok_01, data_ok_02}, rdata_02);
        end
        step();
        req_02 = 1'b0; data_cache_addr_ok = 1'b0; data_cache_rdata = 32'h7777_7777;
        #1;
        checks++;
        if ({outst_cnt, data_ok_01, data_ok_02, rdata_01} !== {3'd2, 2'b10, 32'h7777_7777}) begin
            errors++; $display("FAIL pp_order1: cnt %0d dok %b r1 %h", outst_cnt, {data_ok_01, data_ok_02}, rdata_01);
        end
        step();
        data_cache_rdata = 32'h8888_8888;
        #1;
        checks++;
        if ({outst_cnt, data_ok_01, data_ok_02, rdata_02} !== {3'd1, 2'b01, 32'h8888_8888}) begin
            errors++; $display("FAIL pp_order2: cnt %0d dok %b r2 %h", outst_cnt, {data_ok_01, data_ok_02}, rdata_02);
        end
        step();
        data_cache_data_ok = 1'b0; data_cache_rdata = 32'h0;
        #1;
        checks++;
        if (outst_cnt !== 3'd0) begin errors++; $display("FAIL pp_cnt0: got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_err_unexp();
        step();
        data_cache_data_ok = 1'b1; data_cache_rdata = 32'h9999_9999;
        #1;
        checks++;
        if ({data_ok_01, data_ok_02, rdata_01, rdata_02, err_unexp} !== 67'h0) begin
            errors++; $display("FAIL err_noresp: dok %b r1 %h r2 %h err %b", {data_ok_01, data_ok_02}, rdata_01, rdata_02, err_unexp);
        end
        step();
        data_cache_data_ok = 1'b0; data_cache_rdata = 32'h0;
        #1;
        checks++;
        if ({err_unexp, outst_cnt} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL err_set: err %b cnt %0d exp 1 0", err_unexp, outst_cnt);
        end
        repeat (3) step();
        checks++;
        if (err_unexp !== 1'b1) begin errors++; $display("FAIL err_sticky: err %b exp 1", err_unexp); end
    endtask

    task automatic test_async_reset();
        step();
        req_01 = 1'b1; addr_01 = 32'h0000_A000; data_cache_addr_ok = 1'b1;
        repeat (2) step();
        step();
        data_cache_addr_ok = 1'b0; addr_01 = 32'h0000_B000;
        #1;
        checks++;
        if ({outst_cnt, data_cache_req, addr_ok_01} !== {3'd3, 2'b10}) begin
            errors++; $display("FAIL ar_setup: cnt %0d req %b ok1 %b", outst_cnt, data_cache_req, addr_ok_01);
        end
        step();
        #1;
        checks++;
        if (data_cache_addr !== 32'h0000_B000) begin
            errors++; $display("FAIL ar_lock: addr %h exp 0000b000", data_cache_addr);
        end
        #1;
        reset = 1'b1; data_cache_data_ok = 1'b1; data_cache_rdata = 32'hAAAA_AAAA;
        #1;
        checks++;
        if ({data_cache_req, addr_ok_01, data_ok_01, data_ok_02, outst_cnt, err_unexp} !== 8'h0) begin
            errors++; $display("FAIL ar_outputs: req %b ok1 %b dok %b cnt %0d err %b",
                               data_cache_req, addr_ok_01, {data_ok_01, data_ok_02}, outst_cnt, err_unexp);
        end
        checks++;
        if ({data_cache_addr, rdata_01} !== 64'h0) begin
            errors++; $display("FAIL ar_data: addr %h r1 %h exp 0", data_cache_addr, rdata_01);
        end
        step();
        reset = 1'b0; data_cache_data_ok = 1'b0; data_cache_rdata = 32'h0;
        req_01 = 1'b0; req_02 = 1'b1; addr_02 = 32'h0000_C000; data_cache_addr_ok = 1'b1;
        #1;
        checks++;
        if ({data_cache_req, addr_ok_02, data_cache_addr, outst_cnt} !== {2'b11, 32'h0000_C000, 3'd0}) begin
            errors++; $display("FAIL ar_idle: req %b ok2 %b addr %h cnt %0d", data_cache_req, addr_ok_02, data_cache_addr, outst_cnt);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (outst_cnt !== 3'd1) begin errors++; $display("FAIL ar_after: cnt %0d exp 1", outst_cnt); end
    endtask

    initial begin
        test_reset();
        test_both_slots();
        test_lock02();
        test_full();
        test_push_pop();
        test_err_unexp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
